// File: rtl/daq_pkg.sv
// ----------------------------------------------------------------------------
// daq_pkg
// Shared definitions for the sampler-to-readout event path:
//   - default geometry of a captured event (channels, samples, stream width)
//   - the frame header magic byte
//   - the event_streamer FSM state encoding
//   - words_per_frame(): number of stream words in one framed event
// No ports (package).
// ----------------------------------------------------------------------------
package daq_pkg;

  localparam int unsigned DEF_N_CH    = 32'd16;
  localparam int unsigned DEF_SAMPLES = 32'd64;
  localparam int unsigned DEF_WORD_W  = 32'd32;

  localparam logic [7:0] HDR_MAGIC = 8'hE5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LATCH   = 3'd1,
    ST_HEADER  = 3'd2,
    ST_TSTAMP  = 3'd3,
    ST_PAYLOAD = 3'd4
  } stream_state_e;

  // Header word, optional timestamp word, then the whole event packed in words.
  function automatic int unsigned words_per_frame(
    input int unsigned n_ch,
    input int unsigned samples,
    input int unsigned word_w,
    input bit          ts_en
  );
    return (n_ch * samples / word_w) + 32'd1 + (ts_en ? 32'd1 : 32'd0);
  endfunction

endpackage

// File: rtl/timestamp_counter.sv
// ----------------------------------------------------------------------------
// timestamp_counter
// Free-running 32-bit cycle counter, cleared by reset, wraps at 2^32.
// Only present when EVENT_STREAMER_TIMESTAMP_EN is defined; without the macro
// the module is not part of the build at all.
// Ports:
//   clk      in   system clock
//   aresetn  in   asynchronous active-low reset
//   count    out  [31:0] current cycle count
// ----------------------------------------------------------------------------
`ifdef EVENT_STREAMER_TIMESTAMP_EN
module timestamp_counter (
  input  logic        clk,
  input  logic        aresetn,
  output logic [31:0] count
);

  logic [31:0] count_r;

  // Cycle counter, counts every clock after reset release.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      count_r <= 32'd0;
    end else begin
      count_r <= count_r + 32'd1;
    end
  end

  assign count = count_r;

endmodule
`endif

// File: rtl/event_streamer.sv
// ----------------------------------------------------------------------------
// event_streamer
// Consumer side of the sampler event handshake. A captured event is latched in
// one cycle (acknowledged with a single-cycle event_saved) and then sent as a
// framed AXI4-Stream: header word, optional timestamp word, payload words.
// The sampler is held off until the frame has fully drained.
//
// Optional feature macro: EVENT_STREAMER_TIMESTAMP_EN
//   defined   -> a free-running cycle counter is latched with each event and
//                sent as an extra word right after the header
//   undefined -> header + payload only
//
// Ports:
//   clk          in   system clock
//   aresetn      in   asynchronous active-low reset
//   event_valid  in   sampler holds a captured event
//   evento       in   [N_CH-1:0][SAMPLES-1:0] event, bit 0 = oldest sample
//   event_saved  out  one-cycle acknowledge (high during the latch cycle)
//   m_tdata      out  [WORD_W-1:0] stream data
//   m_tvalid     out  stream valid
//   m_tready     in   stream ready
//   m_tlast      out  last word of the frame
//   event_count  out  [15:0] events latched since reset (wraps)
// ----------------------------------------------------------------------------
module event_streamer
  import daq_pkg::*;
#(
  parameter int unsigned N_CH    = DEF_N_CH,
  parameter int unsigned SAMPLES = DEF_SAMPLES,
  parameter int unsigned WORD_W  = DEF_WORD_W
) (
  input  logic                              clk,
  input  logic                              aresetn,
  input  logic                              event_valid,
  input  logic [N_CH-1:0][SAMPLES-1:0]      evento,
  output logic                              event_saved,
  output logic [WORD_W-1:0]                 m_tdata,
  output logic                              m_tvalid,
  input  logic                              m_tready,
  output logic                              m_tlast,
  output logic [15:0]                       event_count
);

`ifdef EVENT_STREAMER_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  localparam int unsigned FRAME_WORDS   = words_per_frame(N_CH, SAMPLES, WORD_W, TS_EN);
  localparam int unsigned PAYLOAD_WORDS = FRAME_WORDS - 32'd1 - (TS_EN ? 32'd1 : 32'd0);
  localparam int unsigned IDX_W         = $clog2(PAYLOAD_WORDS + 32'd1);
  localparam int unsigned SEL_W         = $clog2(PAYLOAD_WORDS);

  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(PAYLOAD_WORDS - 32'd1);
  localparam logic [SEL_W-1:0] SEL_FIRST   = '0;
  localparam logic             SINGLE_WORD = (PAYLOAD_WORDS == 32'd1);

  // Buffer viewed as payload words: word 0 is channel 0 low bits, matching
  // the stream order (channel-major, low half first).
  logic [PAYLOAD_WORDS-1:0][WORD_W-1:0] buf_r;

  stream_state_e      state_r, state_nxt_s;
  logic               saved_r, saved_nxt_s;
  logic               valid_r, valid_nxt_s;
  logic               last_r,  last_nxt_s;
  logic [WORD_W-1:0]  data_r,  data_nxt_s;
  logic [IDX_W-1:0]   idx_r,   idx_nxt_s;
  logic [IDX_W-1:0]   idx_inc_s;
  logic [15:0]        count_r, count_nxt_s;
  logic               xfer_s;

`ifdef EVENT_STREAMER_TIMESTAMP_EN
  logic [31:0] ts_now_s;
  logic [31:0] ts_r;

  timestamp_counter u_timestamp_counter (
    .clk     (clk),
    .aresetn (aresetn),
    .count   (ts_now_s)
  );

  // Timestamp is taken in the same cycle the event is copied.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      ts_r <= 32'd0;
    end else if (state_r == ST_LATCH) begin
      ts_r <= ts_now_s;
    end else begin
      ts_r <= ts_r;
    end
  end
`endif

  assign xfer_s    = valid_r & m_tready;
  assign idx_inc_s = idx_r + IDX_W'(1);

  // Event buffer: pure data path, only meaningful after a latch, so no reset.
  always_ff @(posedge clk) begin
    if (state_r == ST_LATCH) begin
      buf_r <= evento;
    end
  end

  // Next-state and next-output logic; outputs are registered so every stream
  // signal comes straight from a flop and holds naturally during stalls.
  always_comb begin
    state_nxt_s = state_r;
    saved_nxt_s = 1'b0;
    valid_nxt_s = valid_r;
    last_nxt_s  = last_r;
    data_nxt_s  = data_r;
    idx_nxt_s   = idx_r;
    count_nxt_s = count_r;

    case (state_r)
      ST_IDLE: begin
        valid_nxt_s = 1'b0;
        last_nxt_s  = 1'b0;
        if (event_valid) begin
          state_nxt_s = ST_LATCH;
          saved_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_LATCH: begin
        // Header carries the count before this event is added.
        count_nxt_s = count_r + 16'd1;
        state_nxt_s = ST_HEADER;
        valid_nxt_s = 1'b1;
        last_nxt_s  = 1'b0;
        data_nxt_s  = WORD_W'({HDR_MAGIC, 8'(N_CH), count_r});
      end

      ST_HEADER: begin
        if (xfer_s) begin
`ifdef EVENT_STREAMER_TIMESTAMP_EN
          state_nxt_s = ST_TSTAMP;
          data_nxt_s  = WORD_W'(ts_r);
          last_nxt_s  = 1'b0;
`else
          state_nxt_s = ST_PAYLOAD;
          idx_nxt_s   = '0;
          data_nxt_s  = buf_r[SEL_FIRST];
          last_nxt_s  = SINGLE_WORD;
`endif
        end else begin
          state_nxt_s = ST_HEADER;
        end
      end

`ifdef EVENT_STREAMER_TIMESTAMP_EN
      ST_TSTAMP: begin
        if (xfer_s) begin
          state_nxt_s = ST_PAYLOAD;
          idx_nxt_s   = '0;
          data_nxt_s  = buf_r[SEL_FIRST];
          last_nxt_s  = SINGLE_WORD;
        end else begin
          state_nxt_s = ST_TSTAMP;
        end
      end
`endif

      ST_PAYLOAD: begin
        if (xfer_s) begin
          if (last_r) begin
            state_nxt_s = ST_IDLE;
            valid_nxt_s = 1'b0;
            last_nxt_s  = 1'b0;
            data_nxt_s  = '0;
          end else begin
            state_nxt_s = ST_PAYLOAD;
            idx_nxt_s   = idx_inc_s;
            data_nxt_s  = buf_r[idx_inc_s[SEL_W-1:0]];
            last_nxt_s  = (idx_inc_s == LAST_IDX);
          end
        end else begin
          state_nxt_s = ST_PAYLOAD;
        end
      end

      default: begin
        // Unreachable encodings recover to a clean idle with no open frame.
        state_nxt_s = ST_IDLE;
        valid_nxt_s = 1'b0;
        last_nxt_s  = 1'b0;
        data_nxt_s  = '0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame without a tlast.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_r <= ST_IDLE;
      saved_r <= 1'b0;
      valid_r <= 1'b0;
      last_r  <= 1'b0;
      data_r  <= '0;
      idx_r   <= '0;
      count_r <= 16'd0;
    end else begin
      state_r <= state_nxt_s;
      saved_r <= saved_nxt_s;
      valid_r <= valid_nxt_s;
      last_r  <= last_nxt_s;
      data_r  <= data_nxt_s;
      idx_r   <= idx_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  assign event_saved = saved_r;
  assign m_tvalid    = valid_r;
  assign m_tlast     = last_r;
  assign m_tdata     = data_r;
  assign event_count = count_r;

endmodule
